// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and constants for the 4:1 round-robin
//               arbitrated mux front end.
//               sel_t   - 2-bit channel index (0=a, 1=b, 2=c, 3=d)
//               state_e - output register occupancy (EMPTY / FULL)
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

  // Number of arbitrated channels.
  localparam int NUM_CH = 4;

  // Burst counter width: wide enough for MAX_BURST up to 15.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  // Output register occupancy. FULL is exactly out_valid=1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin picker.
//               Scans last+1, last+2, last+3, last (mod 4) and grants the
//               first requester. When hold_en_i is set and the previous
//               winner is still requesting, the previous winner is granted
//               again (burst continuation).
// Ports       : req_i      in  4  request vector, bit0=a .. bit3=d
//               last_i     in  2  index of the previous winner
//               hold_en_i  in  1  allow re-grant of last_i
//               gnt_o      out 4  one-hot grant, zero when no request
//               gnt_idx_o  out 2  encoded grant index (valid with gnt_vld_o)
//               gnt_vld_o  out 1  a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import mux_pkg::*;
(
  input  logic [3:0] req_i,
  input  sel_t       last_i,
  input  logic       hold_en_i,
  output logic [3:0] gnt_o,
  output sel_t       gnt_idx_o,
  output logic       gnt_vld_o
);

  sel_t w_cand;

  always_comb begin
    gnt_o     = 4'b0000;
    gnt_idx_o = last_i;
    gnt_vld_o = 1'b0;
    w_cand    = last_i;

    if (hold_en_i && req_i[last_i]) begin
      gnt_o     = 4'b0001 << last_i;
      gnt_idx_o = last_i;
      gnt_vld_o = 1'b1;
    end else begin
      // k=4 wraps back onto last_i, so a lone requester that just won is
      // granted again without needing the burst path.
      for (int k = 1; k <= NUM_CH; k++) begin
        w_cand = last_i + sel_t'(k);
        if (!gnt_vld_o && req_i[w_cand]) begin
          gnt_o     = 4'b0001 << w_cand;
          gnt_idx_o = w_cand;
          gnt_vld_o = 1'b1;
        end
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux_4to1_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mux_4to1_rr_arb
// Description : Round-robin arbiter for four WIDTH-bit producer channels
//               feeding a single-entry registered output stream. The winning
//               word and its 2-bit channel code are registered together.
//               Full throughput of one word per clock; accept-to-valid
//               latency is one clock.
// Ports       : clk        in   1      rising-edge clock
//               rst        in   1      synchronous reset, active-high
//               in_valid   in   4      per-channel request, bit0=a .. bit3=d
//               in_ready   out  4      per-channel accept, one-hot or zero
//               a,b,c,d    in   WIDTH  channel data, sampled on accept
//               out_valid  out  1      out_data/sel hold a word
//               out_ready  in   1      consumer accepts the held word
//               out_data   out  WIDTH  registered winning word
//               sel        out  2      registered winning channel index
// Parameters  : WIDTH      data width
//               MAX_BURST  max consecutive grants to one channel while
//                          others request (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4to1_rr_arb
  import mux_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output sel_t             sel
);

  localparam cnt_t C_MAX_CNT = cnt_t'(MAX_BURST);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  sel_t             sel_q,   sel_d;
  sel_t             last_q,  last_d;
  cnt_t             cnt_q,   cnt_d;

  // --------------------------------------------------------------------------
  // Handshake and arbitration
  // --------------------------------------------------------------------------
  logic             w_load;
  logic             w_hold_en;
  logic [3:0]       w_req;
  logic [3:0]       w_gnt;
  sel_t             w_gnt_idx;
  logic             w_gnt_vld;
  logic [WIDTH-1:0] w_win_data;

  // The register can take a new word when empty or when its word drains now.
  assign w_load = (state_q == ST_EMPTY) | out_ready;

  // cnt_q==0 only right after reset: there is no burst in progress then, so
  // round-robin from last=3 puts channel a first.
  assign w_hold_en = (cnt_q != '0) && (cnt_q < C_MAX_CNT);

  // Requests are masked while stalled or in reset so in_ready stays zero.
  assign w_req = in_valid & {4{w_load & ~rst}};

  rr_pick4 u_pick (
    .req_i     (w_req),
    .last_i    (last_q),
    .hold_en_i (w_hold_en),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_vld_o (w_gnt_vld)
  );

  assign in_ready = w_gnt;

  always_comb begin
    w_win_data = a;
    unique case (w_gnt_idx)
      SEL_A:   w_win_data = a;
      SEL_B:   w_win_data = b;
      SEL_C:   w_win_data = c;
      SEL_D:   w_win_data = d;
      default: w_win_data = a;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    if (w_gnt_vld) begin
      // Transfer: capture winner; drain and refill in the same cycle is fine.
      state_d = ST_FULL;
      data_d  = w_win_data;
      sel_d   = w_gnt_idx;
      last_d  = w_gnt_idx;
      if (w_gnt_idx == last_q) begin
        cnt_d = (cnt_q >= C_MAX_CNT) ? C_MAX_CNT : cnt_q + cnt_t'(1);
      end else begin
        cnt_d = cnt_t'(1);
      end
    end else if (w_load) begin
      // Drained (or already empty) with nothing to accept.
      state_d = ST_EMPTY;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= SEL_A;
      last_q  <= SEL_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

endmodule : mux_4to1_rr_arb
`default_nettype wire
